// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : song_sequencer
// Brief    : Playlist controller above song_reader: play/pause, skip,
//            auto-advance with optional repeat, end-of-playlist pulse.
// Revision : 1.0 - initial release
// ============================================================================
module song_sequencer #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_play_button,
    input  logic              i_next_button,
    input  logic              i_repeat_en,
    input  logic              i_song_done,
    output logic              o_play,
    output logic [SONG_W-1:0] o_song,
    output logic              o_reset_player,
    output logic              o_playlist_done
);

    localparam logic [1:0] c_ST_INIT    = 2'd0;
    localparam logic [1:0] c_ST_PAUSED  = 2'd1;
    localparam logic [1:0] c_ST_PLAYING = 2'd2;
    localparam logic [1:0] c_ST_ADVANCE = 2'd3;

    localparam logic [SONG_W-1:0] c_LAST_SONG = SONG_W'(NUM_SONGS - 1);

    logic [1:0]        r_state;
    logic [SONG_W-1:0] r_song;
    logic              r_resume;
    logic              r_auto;
    logic              w_last;
    logic              w_end_of_list;

    assign w_last        = (r_song == c_LAST_SONG);
    assign w_end_of_list = r_auto && w_last && !i_repeat_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_INIT;
            r_song   <= '0;
            r_resume <= 1'b0;
            r_auto   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    r_state <= c_ST_PAUSED;
                end
                c_ST_PAUSED: begin
                    if (i_next_button) begin
                        r_state  <= c_ST_ADVANCE;
                        r_resume <= 1'b0;
                        r_auto   <= 1'b0;
                    end else if (i_play_button) begin
                        r_state <= c_ST_PLAYING;
                    end
                end
                c_ST_PLAYING: begin
                    // A manual skip wins over a coincident song_done
                    if (i_next_button) begin
                        r_state  <= c_ST_ADVANCE;
                        r_resume <= 1'b1;
                        r_auto   <= 1'b0;
                    end else if (i_song_done) begin
                        r_state  <= c_ST_ADVANCE;
                        r_resume <= 1'b1;
                        r_auto   <= 1'b1;
                    end else if (i_play_button) begin
                        r_state <= c_ST_PAUSED;
                    end
                end
                default: begin
                    r_song <= w_last ? '0 : r_song + 1'b1;
                    if (w_end_of_list || !r_resume) begin
                        r_state <= c_ST_PAUSED;
                    end else begin
                        r_state <= c_ST_PLAYING;
                    end
                end
            endcase
        end
    end

    assign o_play          = (r_state == c_ST_PLAYING);
    assign o_song          = r_song;
    assign o_reset_player  = (r_state == c_ST_INIT) || (r_state == c_ST_ADVANCE);
    assign o_playlist_done = (r_state == c_ST_ADVANCE) && w_end_of_list;

endmodule
`default_nettype wire
